// File: rtl/ping_pkg.sv
// Purpose : shared types and defaults for the ping/pong delay initiator.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package ping_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_RDY  = 3'd1,
      PING      = 3'd2,
      WAIT_PONG = 3'd3,
      OUT       = 3'd4
   } ping_state_t;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_TIMEOUT    = 60000;

endpackage

// File: rtl/ping_timer.sv
// Purpose : saturating round-trip counter; stops at TIMEOUT so it never wraps.
// Latency : clear/increment take effect on the next clock edge.
// Backpressure: none; counts whenever enabled.
//
// Ports:
//   clk, reset     - clock, async active-high reset
//   clr_i          - force count to 0 (wins over en_i)
//   en_i           - increment by 1 unless already at TIMEOUT
//   cnt_o          - current count
//   hit_timeout_o  - count equals TIMEOUT
module ping_timer
   import ping_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr_i,
   input  logic                  en_i,
   output logic [DATA_WIDTH-1:0] cnt_o,
   output logic                  hit_timeout_o
);

   localparam logic [DATA_WIDTH-1:0] TO_VAL = DATA_WIDTH'(TIMEOUT);

   logic [DATA_WIDTH-1:0] cnt_q;
   logic [DATA_WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != TO_VAL)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o         = cnt_q;
   assign hit_timeout_o = (cnt_q == TO_VAL);

endmodule

// File: rtl/ping_ranger.sv
// Purpose : initiator of the ping/pong link; runs DLY_NUM round-trip measurements per start.
// Latency : start->ping 2 cycles (ping_ready high); pong at ping+n gives m_tvalid at ping+n+1.
// Backpressure: single-entry output register; no new ping while a beat is pending.
//
// Ports:
//   clk, reset          - clock, async active-high reset
//   start               - begin a burst (ignored while busy)
//   ping_ready, pong    - responder handshake inputs
//   ping                - registered one-cycle ping pulse
//   m_tvalid/m_tready   - stream handshake; m_tdata = delay or TIMEOUT,
//   m_tuser             - 1 on timeout beats, m_tlast on final beat of burst
//   busy, done          - FSM not idle / one-cycle pulse after last beat accepted
//   stray_pong          - sticky: pong seen outside WAIT_PONG, cleared by accepted start
module ping_ranger
   import ping_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DLY_NUM    = 3,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  ping_ready,
   input  logic                  pong,
   output logic                  ping,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tuser,
   output logic                  m_tlast,
   output logic                  busy,
   output logic                  done,
   output logic                  stray_pong
);

   localparam int                    IDX_W    = (DLY_NUM > 1) ? $clog2(DLY_NUM) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DLY_NUM - 1);
   localparam logic [DATA_WIDTH-1:0] TO_VAL   = DATA_WIDTH'(TIMEOUT);

   ping_state_t           state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  ping_q, ping_d;
   logic                  vld_q, vld_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  user_q, user_d;
   logic                  done_q, done_d;
   logic                  stray_q, stray_d;

   logic                  tmr_clr;
   logic                  tmr_en;
   logic [DATA_WIDTH-1:0] tmr_cnt;
   logic                  tmr_hit;
   logic                  accept;
   logic                  last_beat;

   assign accept    = vld_q && m_tready;
   assign last_beat = (idx_q == LAST_IDX);

   ping_timer #(
      .DATA_WIDTH (DATA_WIDTH),
      .TIMEOUT    (TIMEOUT)
   ) u_timer (
      .clk           (clk),
      .reset         (reset),
      .clr_i         (tmr_clr),
      .en_i          (tmr_en),
      .cnt_o         (tmr_cnt),
      .hit_timeout_o (tmr_hit)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (start)            state_d = WAIT_RDY;
         WAIT_RDY:  if (ping_ready)       state_d = PING;
         PING:                            state_d = WAIT_PONG;
         WAIT_PONG: if (pong || tmr_hit)  state_d = OUT;
         OUT:       if (accept)           state_d = last_beat ? IDLE : WAIT_RDY;
         default:                         state_d = IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      idx_d   = idx_q;
      ping_d  = 1'b0;
      vld_d   = vld_q;
      data_d  = data_q;
      user_d  = user_q;
      done_d  = 1'b0;
      stray_d = stray_q;
      tmr_clr = 1'b0;
      tmr_en  = 1'b0;

      if ((state_q == IDLE) && start) begin
         idx_d   = '0;
         stray_d = 1'b0;
      end
      // A pong in the same cycle as an accepted start still counts as stray.
      if (pong && (state_q != WAIT_PONG)) begin
         stray_d = 1'b1;
      end

      case (state_q)
         WAIT_RDY: begin
            // Clear on the way into PING so the count reads 0 during the ping
            // cycle and n exactly n cycles later.
            if (ping_ready) begin
               ping_d  = 1'b1;
               tmr_clr = 1'b1;
            end
         end
         PING: begin
            tmr_en = 1'b1;
         end
         WAIT_PONG: begin
            tmr_en = 1'b1;
            // pong takes priority over a simultaneous timeout
            if (pong) begin
               vld_d  = 1'b1;
               data_d = tmr_cnt;
               user_d = 1'b0;
            end else if (tmr_hit) begin
               vld_d  = 1'b1;
               data_d = TO_VAL;
               user_d = 1'b1;
            end
         end
         OUT: begin
            if (accept) begin
               vld_d = 1'b0;
               if (last_beat) begin
                  done_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q   <= '0;
         ping_q  <= 1'b0;
         vld_q   <= 1'b0;
         data_q  <= '0;
         user_q  <= 1'b0;
         done_q  <= 1'b0;
         stray_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         ping_q  <= ping_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
         user_q  <= user_d;
         done_q  <= done_d;
         stray_q <= stray_d;
      end
   end

   assign ping       = ping_q;
   assign m_tvalid   = vld_q;
   assign m_tdata    = data_q;
   assign m_tuser    = user_q;
   assign m_tlast    = (state_q == OUT) && last_beat;
   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign stray_pong = stray_q;

endmodule
